sap: RTL and testbench

- SAP-1 class 8-bit educational CPU, self-contained: program counter, memory address register, 16x8 RAM, instruction register, accumulator A, B register, add/sub ALU, output register and 6-state ring-counter controller.
- Runs the program preloaded in RAM from reset until it executes HLT, then raises the sticky `halt` output.
- Top-level compute block; its only external interface is clock, reset and halt.

---
 rtl/sap_pkg.sv | 22 ++
 rtl/sap_control.sv | 55 +++++
 rtl/sap.sv | 59 +++++
 tb/tb_sap.sv | 125 ++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// sap_pkg: opcodes, controller states, RAM image type and default program for the SAP-1 CPU
package sap_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {T1, T2, T3, T4, T5, T6} tstate_t;

    typedef logic [15:0][7:0] ram_t;

    localparam ram_t DEFAULT_PROGRAM = '{
        0: 8'h09, 1: 8'h1A, 2: 8'h2B, 3: 8'hE0, 4: 8'hF0,
        9: 8'h10, 10: 8'h14, 11: 8'h18,
        default: 8'h00
    };

endpackage

// File: rtl/sap_control.sv
// sap_control: six-state ring counter, opcode decode and control word, frozen once halted
module sap_control
    import sap_pkg::*;
(
    input  logic       sap_clock,
    input  logic       sap_reset,
    input  logic [3:0] opcode,
    output logic       halt,
    output logic       pc_inc,
    output logic       mar_ld_pc,
    output logic       mar_ld_ir,
    output logic       ir_ld,
    output logic       a_ld_mem,
    output logic       b_ld_mem,
    output logic       a_ld_alu,
    output logic       alu_sub,
    output logic       out_ld,
    output logic       halt_set
);

    tstate_t state_q, state_n;
    logic    halt_q, run, is_lda, is_add, is_sub, is_mem;

    always_ff @(posedge sap_clock or negedge sap_reset) begin
        if (!sap_reset) begin
            state_q <= T1;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            if (halt_set) halt_q <= 1'b1;
        end
    end

    always_comb begin
        state_n   = halt_q ? state_q : (state_q == T6 ? T1 : tstate_t'(state_q + 3'd1));
        run       = !halt_q;
        is_lda    = opcode == OP_LDA;
        is_add    = opcode == OP_ADD;
        is_sub    = opcode == OP_SUB;
        is_mem    = is_lda || is_add || is_sub;
        mar_ld_pc = run && state_q == T1;
        pc_inc    = run && state_q == T2;
        ir_ld     = run && state_q == T3;
        mar_ld_ir = run && state_q == T4 && is_mem;
        out_ld    = run && state_q == T4 && opcode == OP_OUT;
        halt_set  = run && state_q == T4 && opcode == OP_HLT;
        a_ld_mem  = run && state_q == T5 && is_lda;
        b_ld_mem  = run && state_q == T5 && (is_add || is_sub);
        a_ld_alu  = run && state_q == T6 && (is_add || is_sub);
        alu_sub   = is_sub;
    end

    assign halt = halt_q;

endmodule

// File: rtl/sap.sv
// sap: SAP-1 8-bit CPU datapath (PC, MAR, RAM, IR, A, B, ALU, output register) around sap_control
module sap
    import sap_pkg::*;
#(
    parameter ram_t PROGRAM = DEFAULT_PROGRAM
) (
    input  logic sap_clock,
    input  logic sap_reset,
    output logic halt
);

    ram_t       ram_q;
    logic [3:0] pc_q, mar_q;
    logic [7:0] ir_q, a_q, b_q, out_q, mem, alu;
    logic       pc_inc, mar_ld_pc, mar_ld_ir, ir_ld, a_ld_mem, b_ld_mem, a_ld_alu, alu_sub, out_ld, halt_set;

    sap_control u_control (
        .sap_clock (sap_clock),
        .sap_reset (sap_reset),
        .opcode    (ir_q[7:4]),
        .halt      (halt),
        .pc_inc    (pc_inc),
        .mar_ld_pc (mar_ld_pc),
        .mar_ld_ir (mar_ld_ir),
        .ir_ld     (ir_ld),
        .a_ld_mem  (a_ld_mem),
        .b_ld_mem  (b_ld_mem),
        .a_ld_alu  (a_ld_alu),
        .alu_sub   (alu_sub),
        .out_ld    (out_ld),
        .halt_set  (halt_set)
    );

    assign mem = ram_q[mar_q];
    assign alu = alu_sub ? a_q - b_q : a_q + b_q;

    // RAM has no write path: it only ever takes the program image on reset
    always_ff @(posedge sap_clock or negedge sap_reset) begin
        if (!sap_reset) begin
            ram_q <= PROGRAM;
            pc_q  <= '0;
            mar_q <= '0;
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            out_q <= '0;
        end else begin
            if (mar_ld_pc) mar_q <= pc_q;
            if (mar_ld_ir) mar_q <= ir_q[3:0];
            if (pc_inc) pc_q <= pc_q + 4'd1;
            if (ir_ld) ir_q <= mem;
            if (a_ld_mem) a_q <= mem;
            if (a_ld_alu) a_q <= alu;
            if (b_ld_mem) b_q <= mem;
            if (out_ld) out_q <= a_q;
        end
    end

endmodule

// File: tb/tb_sap.sv
// tb_sap: runs five program images side by side and checks final state, halt timing, freeze and mid-run reset
module tb_sap;
    import sap_pkg::*;

    localparam int N = 5;

    localparam ram_t PROGS [N] = '{
        DEFAULT_PROGRAM,
        '{0: 8'h05, 1: 8'h26, 2: 8'hE0, 3: 8'h70, 4: 8'hF0, 5: 8'h05, 6: 8'h07, default: 8'h00},
        '{0: 8'h30, 1: 8'h09, 2: 8'hE0, 3: 8'h50, 4: 8'hF0, 9: 8'h42, default: 8'h00},
        '{15: 8'hF0, default: 8'h00},
        '{0: 8'h08, 1: 8'h19, 2: 8'hE0, 3: 8'h70, 4: 8'hF0, 8: 8'hF0, 9: 8'h20, default: 8'h00}
    };

    typedef struct packed {
        logic [3:0] pc;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ir;
        logic [7:0] out;
    } obs_t;

    typedef struct {
        string      name;
        int         halt_edge;
        logic [3:0] pc;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ir;
        logic [7:0] out;
    } vec_t;

    logic     sap_clock = 1'b0;
    logic     sap_reset = 1'b0;
    logic     halt_w [N];
    obs_t     obs [N];
    vec_t     vecs [N];
    int       halt_edge [N];
    int       total = 0;
    int       passed = 0;
    obs_t     snap;

    always #5 sap_clock = ~sap_clock;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sap #(.PROGRAM(PROGS[g])) u_sap (
            .sap_clock (sap_clock),
            .sap_reset (sap_reset),
            .halt      (halt_w[g])
        );
        assign obs[g] = {u_sap.pc_q, u_sap.a_q, u_sap.b_q, u_sap.ir_q, u_sap.out_q};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic run_edges(input int n);
        for (int i = 0; i < N; i++) halt_edge[i] = 0;
        for (int e = 1; e <= n; e++) begin
            @(posedge sap_clock);
            #1;
            for (int i = 0; i < N; i++)
                if (halt_w[i] === 1'b1 && halt_edge[i] == 0) halt_edge[i] = e;
            if (e == 30) snap = obs[0];
            if (e == 50) chk("freeze default", obs[0], snap);
        end
    endtask

    task automatic check_table();
        for (int i = 0; i < N; i++) begin
            chk({vecs[i].name, " halt_edge"}, halt_edge[i], vecs[i].halt_edge);
            chk({vecs[i].name, " halt"}, halt_w[i], 1'b1);
            chk({vecs[i].name, " pc"}, obs[i].pc, vecs[i].pc);
            chk({vecs[i].name, " a"}, obs[i].a, vecs[i].a);
            chk({vecs[i].name, " b"}, obs[i].b, vecs[i].b);
            chk({vecs[i].name, " ir"}, obs[i].ir, vecs[i].ir);
            chk({vecs[i].name, " out"}, obs[i].out, vecs[i].out);
        end
    endtask

    initial begin
        vecs[0] = '{"default",   28, 4'd5, 8'h0C, 8'h18, 8'hF0, 8'h0C};
        vecs[1] = '{"underflow", 28, 4'd5, 8'hFE, 8'h07, 8'hF0, 8'hFE};
        vecs[2] = '{"undef_op",  28, 4'd5, 8'h42, 8'h00, 8'hF0, 8'h42};
        vecs[3] = '{"pc_wrap",   94, 4'd0, 8'h00, 8'h00, 8'hF0, 8'h00};
        vecs[4] = '{"overflow",  28, 4'd5, 8'h10, 8'h20, 8'hF0, 8'h10};
        #10;
        for (int i = 0; i < N; i++) begin
            chk("reset state", obs[i], '0);
            chk("reset halt", halt_w[i], 1'b0);
        end
        @(negedge sap_clock);
        sap_reset = 1'b1;
        run_edges(120);
        check_table();
        // abort mid-instruction: edge 15 lies inside instruction 3
        @(negedge sap_clock);
        sap_reset = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk("mid reset state", obs[i], '0);
            chk("mid reset halt", halt_w[i], 1'b0);
        end
        @(negedge sap_clock);
        sap_reset = 1'b1;
        for (int e = 1; e <= 15; e++) @(posedge sap_clock);
        #3;
        sap_reset = 1'b0;
        #1;
        chk("abort pc", obs[0].pc, 4'd0);
        chk("abort a", obs[0].a, 8'h00);
        chk("abort ir", obs[0].ir, 8'h00);
        chk("abort halt", halt_w[0], 1'b0);
        @(negedge sap_clock);
        sap_reset = 1'b1;
        run_edges(120);
        check_table();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
